perf_counter_unit: RTL

Performance-monitoring block instantiated inside the pipelined RV32 core beside the writeback stage. It counts cycles, retired instructions, stall cycles, flushes, control redirects and stores from per-stage pipeline status signals. On the architectural halt store it freezes, so a bench can read the exact CPI inputs with no post-hoc correction. Counter values are exposed as direct outputs and through a registered select/read port.

---
 rtl/perf_counter_unit_pkg.sv | 21 ++
 rtl/perf_counter_unit_sat_counter.sv | 28 ++
 rtl/perf_counter_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/perf_counter_unit_pkg.sv
// Shared definitions for the performance counter unit: counter select
// encoding, FSM state encoding and the number of implemented counters.
package perf_pkg;

    localparam int PERF_NUM_CNT = 6;

    typedef enum logic [2:0] {
        CYCLES    = 3'd0,
        INSTRS    = 3'd1,
        STALLS    = 3'd2,
        FLUSHES   = 3'd3,
        REDIRECTS = 3'd4,
        STORES    = 3'd5
    } perf_sel_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } perf_state_e;

endpackage

// File: rtl/perf_counter_unit_sat_counter.sv
// Saturating up-counter: +1 per cycle when en && inc, sticks at all-ones.
// Ports: clk, reset (sync, active-high), en, inc -> q [W-1:0].
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;
    logic         w_full;

    assign w_full = (r_q == {W{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (en && inc && !w_full) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Pipeline performance counters with freeze-on-halt-store and a registered
// select/read port.
// Ports: clk, reset (sync, active-high); pipeline status InstrValidW,
// StallD, FlushE, PCSrcE, MemWriteM, DataAdrM, WriteDataM; rd_sel selects
// a counter onto rd_data (1-cycle latency); cycle_count, instr_retired
// live counters; halted freeze flag.
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int          CNT_W     = 32,
    parameter logic [31:0] HALT_ADDR = 32'd100,
    parameter logic [31:0] HALT_DATA = 32'd25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InstrValidW,
    input  logic             StallD,
    input  logic             FlushE,
    input  logic             PCSrcE,
    input  logic             MemWriteM,
    input  logic [31:0]      DataAdrM,
    input  logic [31:0]      WriteDataM,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_retired,
    output logic             halted
);

    perf_state_e r_state;
    perf_state_e w_state_nxt;

    logic                    w_halt_hit;
    logic                    w_run;
    logic [PERF_NUM_CNT-1:0] w_inc;
    logic [CNT_W-1:0]        w_cnt [PERF_NUM_CNT];
    logic [CNT_W-1:0]        w_rd_mux;
    logic [CNT_W-1:0]        r_rd_data;

    assign w_halt_hit = MemWriteM
                     && (DataAdrM == HALT_ADDR)
                     && (WriteDataM == HALT_DATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:    if (w_halt_hit) w_state_nxt = ST_HALTED;
            ST_HALTED: w_state_nxt = ST_HALTED;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    // Counters run in the halt-store cycle itself; only the state flop
    // decides the freeze, so that cycle is still counted.
    assign w_run = (r_state == ST_RUN);

    // Bit order follows perf_sel_e; bit 0 is the free-running cycle count.
    assign w_inc = {MemWriteM, PCSrcE, FlushE, StallD, InstrValidW, 1'b1};

    for (genvar g = 0; g < PERF_NUM_CNT; g++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .en    (w_run),
            .inc   (w_inc[g]),
            .q     (w_cnt[g])
        );
    end

    always_comb begin
        w_rd_mux = '0;
        case (perf_sel_e'(rd_sel))
            CYCLES:    w_rd_mux = w_cnt[0];
            INSTRS:    w_rd_mux = w_cnt[1];
            STALLS:    w_rd_mux = w_cnt[2];
            FLUSHES:   w_rd_mux = w_cnt[3];
            REDIRECTS: w_rd_mux = w_cnt[4];
            STORES:    w_rd_mux = w_cnt[5];
            default:   w_rd_mux = '0;
        endcase
    end

    // Keeps sampling while halted so frozen values stay readable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign rd_data       = r_rd_data;
    assign cycle_count   = w_cnt[0];
    assign instr_retired = w_cnt[1];
    assign halted        = (r_state == ST_HALTED);

endmodule
